// File: rtl/seq_gen_core_pkg.sv
// Shared definitions for the sequence generator: step-mode encodings,
// button channel roles and a counter sizing helper.
package seq_gen_core_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,
        MODE_ROT  = 2'b01,
        MODE_JOHN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int BTN_STEP = 0;
    localparam int BTN_LOAD = 1;

    // A debounce threshold of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int deb_cnt);
        return (deb_cnt > 1) ? $clog2(deb_cnt) : 1;
    endfunction

endpackage

// File: rtl/btn_filter_ch.sv
// One button channel: 2-flop synchroniser, tick-based debounce counter,
// debounced level and a single-cycle press pulse.
module btn_filter_ch
    import seq_gen_core_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_ce,
    input  logic btn_raw,
    output logic btn_deb,
    output logic btn_ceo
);

    localparam int CNT_W = cnt_width(DEB_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             deb_r;
    logic             deb_nxt_s;
    logic             ceo_r;
    logic             ceo_nxt_s;

    // Synchroniser flops for the asynchronous raw level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Counter runs only while the synchronised input disagrees with the output.
    always_comb begin
        cnt_nxt_s = cnt_r;
        deb_nxt_s = deb_r;
        ceo_nxt_s = 1'b0;
        if (sync2_r == deb_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (tick_ce) begin
            if (cnt_r == CNT_LAST) begin
                deb_nxt_s = ~deb_r;
                cnt_nxt_s = CNT_ZERO;
                ceo_nxt_s = ~deb_r;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Debounce state and press pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
            deb_r <= 1'b0;
            ceo_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            deb_r <= deb_nxt_s;
            ceo_r <= ceo_nxt_s;
        end
    end

    assign btn_deb = deb_r;
    assign btn_ceo = ceo_r;

endmodule

// File: rtl/seq_gen_core.sv
// Button-driven sequence generator: debounced STEP/LOAD channels advance or
// load a WIDTH-bit sequence in binary, rotate, Johnson or hold mode.
module seq_gen_core
    import seq_gen_core_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int N_BTN   = 2,
    parameter int DEB_CNT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TICK_CE,
    input  logic [N_BTN-1:0] BTN_I,
    input  logic [WIDTH-1:0] DAT_I,
    input  logic             UP,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] SEQ,
    output logic [N_BTN-1:0] BTN_O,
    output logic [N_BTN-1:0] BTN_CEO,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] seq_r;
    logic [WIDTH-1:0] seq_nxt_s;
    logic             wrap_r;
    logic             wrap_nxt_s;
    logic             step_s;
    logic             load_s;
    mode_e            mode_s;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_filter_ch #(
            .DEB_CNT (DEB_CNT)
        ) u_ch (
            .clk     (CLK),
            .rst_n   (RST_N),
            .tick_ce (TICK_CE),
            .btn_raw (BTN_I[i]),
            .btn_deb (BTN_O[i]),
            .btn_ceo (BTN_CEO[i])
        );
    end

    assign step_s = BTN_CEO[BTN_STEP];
    assign load_s = BTN_CEO[BTN_LOAD];
    assign mode_s = mode_e'(MODE);

    // Next sequence value and wrap flag; load has priority over step.
    always_comb begin
        seq_nxt_s  = seq_r;
        wrap_nxt_s = 1'b0;
        if (load_s) begin
            seq_nxt_s  = DAT_I;
            wrap_nxt_s = 1'b0;
        end else if (step_s) begin
            case (mode_s)
                MODE_BIN: begin
                    if (UP) begin
                        seq_nxt_s  = seq_r + ONE;
                        wrap_nxt_s = (seq_r == ALL_ONES);
                    end else begin
                        seq_nxt_s  = seq_r - ONE;
                        wrap_nxt_s = (seq_r == ALL_ZERO);
                    end
                end
                MODE_ROT: begin
                    if (UP) begin
                        seq_nxt_s  = {seq_r[WIDTH-2:0], seq_r[WIDTH-1]};
                        wrap_nxt_s = seq_r[WIDTH-1];
                    end else begin
                        seq_nxt_s  = {seq_r[0], seq_r[WIDTH-1:1]};
                        wrap_nxt_s = seq_r[0];
                    end
                end
                MODE_JOHN: begin
                    if (UP) begin
                        seq_nxt_s  = {seq_r[WIDTH-2:0], ~seq_r[WIDTH-1]};
                        wrap_nxt_s = ({seq_r[WIDTH-2:0], ~seq_r[WIDTH-1]} == ALL_ZERO);
                    end else begin
                        seq_nxt_s  = {~seq_r[0], seq_r[WIDTH-1:1]};
                        wrap_nxt_s = ({~seq_r[0], seq_r[WIDTH-1:1]} == ALL_ZERO);
                    end
                end
                MODE_HOLD: begin
                    seq_nxt_s  = seq_r;
                    wrap_nxt_s = 1'b0;
                end
                default: begin
                    seq_nxt_s  = seq_r;
                    wrap_nxt_s = 1'b0;
                end
            endcase
        end else begin
            seq_nxt_s  = seq_r;
            wrap_nxt_s = 1'b0;
        end
    end

    // Sequence and wrap registers; wrap appears together with the new value.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            seq_r  <= ALL_ZERO;
            wrap_r <= 1'b0;
        end else begin
            seq_r  <= seq_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    assign SEQ  = seq_r;
    assign WRAP = wrap_r;

endmodule
